redbus_arbiter: RTL and testbench

REDBUS_ARBITER -- requirements
Module: redbus_arbiter

---
 rtl/redbus_pkg.sv | 22 ++
 rtl/redbus_rr_arbiter.sv | 25 ++
 rtl/redbus_arbiter.sv | 126 ++++++++++++
 tb/tb_redbus_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/redbus_pkg.sv
// Shared types and constants for the Redbus arbiter: FSM state encoding,
// strobe counter width, default strobe length and the latched transaction record.
package redbus_pkg;

  localparam int CNT_W                 = 4;
  localparam int STROBE_CYCLES_DEFAULT = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETUP  = 2'd1;
  localparam state_t ST_STROBE = 2'd2;
  localparam state_t ST_HOLD   = 2'd3;

  typedef struct packed {
    logic        wr;
    logic [7:0]  dev_id;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } txn_t;

endpackage

// File: rtl/redbus_rr_arbiter.sv
// Two-way round-robin grant: on contention the requester not granted last wins.
// Grant is one-hot ({req1, req0}) and all-zero when update_en is low.
module redbus_rr_arbiter (
  input  logic       req0,
  input  logic       req1,
  input  logic       last_grant,
  input  logic       update_en,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (update_en) begin
      if (req0 && req1) begin
        // last_grant = 1 means requester 1 was served last, so 0 goes now
        grant = last_grant ? 2'b01 : 2'b10;
      end else if (req0) begin
        grant = 2'b01;
      end else if (req1) begin
        grant = 2'b10;
      end
    end
  end

endmodule

// File: rtl/redbus_arbiter.sv
// Redbus master arbiter: grants one of two requesters, runs a fixed-latency
// SETUP / STROBE / HOLD bus cycle and returns a one-cycle Ack with read data.
module redbus_arbiter
  import redbus_pkg::*;
#(
  parameter int STROBE_CYCLES = STROBE_CYCLES_DEFAULT
) (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        Req0,
  input  logic        Req1,
  input  logic        Wr0,
  input  logic        Wr1,
  input  logic [7:0]  DevId0,
  input  logic [7:0]  DevId1,
  input  logic [15:0] Addr0,
  input  logic [15:0] Addr1,
  input  logic [7:0]  WData0,
  input  logic [7:0]  WData1,
  output logic        Ack0,
  output logic        Ack1,
  output logic [7:0]  RData,
  output logic [7:0]  BusDevId,
  output logic [15:0] BusAddress,
  output logic [7:0]  BusDataOut,
  output logic        BusDataOutEn,
  input  logic [7:0]  BusDataIn,
  output logic        ReadRedbus,
  output logic        WriteRedbus
);

  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             last_grant_reg;
  logic             owner_reg, owner_next;
  logic             wr_reg, wr_next;
  logic [1:0]       grant;
  logic             take;
  logic             capture;
  txn_t             txn0, txn1, txn_sel;

  assign txn0 = '{wr: Wr0, dev_id: DevId0, addr: Addr0, wdata: WData0};
  assign txn1 = '{wr: Wr1, dev_id: DevId1, addr: Addr1, wdata: WData1};

  redbus_rr_arbiter u_rr (
    .req0       (Req0),
    .req1       (Req1),
    .last_grant (last_grant_reg),
    .update_en  (state_reg == ST_IDLE),
    .grant      (grant)
  );

  assign take    = |grant;
  assign txn_sel = grant[1] ? txn1 : txn0;
  assign capture = (state_reg == ST_STROBE) && (cnt_reg == '0) && !wr_reg;

  // Direction and owner of the transaction as it will be in the next cycle
  assign wr_next    = take ? txn_sel.wr : wr_reg;
  assign owner_next = take ? grant[1]   : owner_reg;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (take) state_next = ST_SETUP;
      end
      ST_SETUP: begin
        state_next = ST_STROBE;
        cnt_next   = STROBE_LOAD;
      end
      ST_STROBE: begin
        if (cnt_reg == '0) state_next = ST_HOLD;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      ST_HOLD: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Strobes, enable and Ack are registered from the next state so they are
  // glitch-free, and the async reset clears them without waiting for a clock.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      wr_reg         <= 1'b0;
      BusDevId       <= '0;
      BusAddress     <= '0;
      BusDataOut     <= '0;
      RData          <= '0;
      ReadRedbus     <= 1'b0;
      WriteRedbus    <= 1'b0;
      BusDataOutEn   <= 1'b0;
      Ack0           <= 1'b0;
      Ack1           <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      owner_reg <= owner_next;
      wr_reg    <= wr_next;
      if (take) begin
        last_grant_reg <= grant[1];
        BusDevId       <= txn_sel.dev_id;
        BusAddress     <= txn_sel.addr;
        BusDataOut     <= txn_sel.wdata;
      end
      if (capture) RData <= BusDataIn;
      ReadRedbus   <= (state_next == ST_STROBE) && !wr_next;
      WriteRedbus  <= (state_next == ST_STROBE) && wr_next;
      BusDataOutEn <= (state_next != ST_IDLE) && wr_next;
      Ack0         <= (state_next == ST_HOLD) && !owner_next;
      Ack1         <= (state_next == ST_HOLD) && owner_next;
    end
  end

endmodule

// File: tb/tb_redbus_arbiter.sv
// Self-checking bench for redbus_arbiter: directed write/read/contention/reset
// cases, a strobe-length sweep on two extra instances, then randomized traffic.
module tb_redbus_arbiter;
  localparam int SC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_reset;
  logic        req0, req1, wr0, wr1;
  logic [7:0]  dev0, dev1, wd0, wd1, bus_in;
  logic [15:0] addr0, addr1;
  logic        ack0, ack1, dout_en, rd_stb, wr_stb;
  logic [7:0]  rdata, bus_dev, bus_dout;
  logic [15:0] bus_addr;

  // Sweep instances (STROBE_CYCLES = 1 and 15) share their own inputs
  logic        s_req, s_wr, s_zero;
  logic [7:0]  s_dev, s_wd;
  logic [15:0] s_addr;
  logic [1:0]  s_a0, s_a1, s_en, s_rd, s_ws;
  logic [7:0]  s_rdata [2];
  logic [7:0]  s_dev_o [2];
  logic [7:0]  s_dout  [2];
  logic [15:0] s_addr_o [2];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  bit         m_last = 1'b1;   // 1: requester 1 served last
  logic [7:0] m_rdata = 8'h00;

  redbus_arbiter #(.STROBE_CYCLES(SC)) u_dut (
    .Clock(clk), .nReset(n_reset), .Req0(req0), .Req1(req1), .Wr0(wr0), .Wr1(wr1),
    .DevId0(dev0), .DevId1(dev1), .Addr0(addr0), .Addr1(addr1),
    .WData0(wd0), .WData1(wd1), .Ack0(ack0), .Ack1(ack1), .RData(rdata),
    .BusDevId(bus_dev), .BusAddress(bus_addr), .BusDataOut(bus_dout),
    .BusDataOutEn(dout_en), .BusDataIn(bus_in), .ReadRedbus(rd_stb), .WriteRedbus(wr_stb)
  );

  for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
    redbus_arbiter #(.STROBE_CYCLES(gi == 0 ? 1 : 15)) u_sw (
      .Clock(clk), .nReset(n_reset), .Req0(s_req), .Req1(s_zero), .Wr0(s_wr), .Wr1(s_zero),
      .DevId0(s_dev), .DevId1(s_dev), .Addr0(s_addr), .Addr1(s_addr),
      .WData0(s_wd), .WData1(s_wd), .Ack0(s_a0[gi]), .Ack1(s_a1[gi]), .RData(s_rdata[gi]),
      .BusDevId(s_dev_o[gi]), .BusAddress(s_addr_o[gi]), .BusDataOut(s_dout[gi]),
      .BusDataOutEn(s_en[gi]), .BusDataIn(bus_in), .ReadRedbus(s_rd[gi]), .WriteRedbus(s_ws[gi])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] ctl();
    return {rd_stb, wr_stb, dout_en, ack0, ack1};
  endfunction

  // Entered at a negedge with the DUT idle and requests already driven.
  task automatic run_txn(input string tag, input bit fix_in, input logic [7:0] fix_val,
                         input bit scramble);
    bit          g, w, stb;
    logic [7:0]  dv, wd, last_in;
    logic [15:0] ad;
    logic [4:0]  exp_v;
    g = (req0 && req1) ? !m_last : req1;
    w  = g ? wr1 : wr0;
    dv = g ? dev1 : dev0;
    ad = g ? addr1 : addr0;
    wd = g ? wd1 : wd0;
    last_in = 8'h00;
    @(posedge clk);
    for (int j = 1; j <= SC + 2; j++) begin
      @(negedge clk);
      stb   = (j >= 2) && (j <= SC + 1);
      exp_v = {stb && !w, stb && w, w, (j == SC + 2) && !g, (j == SC + 2) && g};
      chk($sformatf("%s/ctl%0d", tag, j), 32'(ctl()), 32'(exp_v));
      chk($sformatf("%s/bus%0d", tag, j), {bus_dev, bus_addr, bus_dout}, {dv, ad, wd});
      if (j == SC + 2) begin
        if (!w) m_rdata = last_in;
        chk($sformatf("%s/rdata", tag), 32'(rdata), 32'(m_rdata));
      end
      if (stb) begin
        bus_in  = fix_in ? fix_val : 8'($urandom);
        last_in = bus_in;
      end
      if (scramble && j == 1) begin
        if (g) {wr1, dev1, addr1, wd1} = 33'({$urandom, $urandom});
        else   {wr0, dev0, addr0, wd0} = 33'({$urandom, $urandom});
      end
    end
    m_last = g;
    if (g) req1 = 1'b0; else req0 = 1'b0;
    @(negedge clk);
    chk({tag, "/idle"}, 32'(ctl()), 32'd0);
    $display("txn %s: grant=%0d wr=%0d dev=%0h addr=%0h wdata=%0h rdata=%0h",
             tag, g, w, dv, ad, wd, rdata);
  endtask

  initial begin
    int strobe_n [2];
    int en_n [2];
    int ack_at [2];
    int ack_n [2];
    int sw_sc [2];
    sw_sc = '{1, 15};
    n_reset = 1'b0;
    {req0, req1, wr0, wr1} = '0;
    {dev0, dev1, wd0, wd1, bus_in} = '0;
    {addr0, addr1} = '0;
    {s_req, s_wr, s_zero, s_dev, s_wd, s_addr} = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset/ctl", 32'(ctl()), 32'd0);
    chk("reset/bus", {bus_dev, bus_addr, bus_dout}, 32'd0);
    chk("reset/rdata", 32'(rdata), 32'd0);
    n_reset = 1'b1;
    @(negedge clk);

    // Single-requester write and read
    req0 = 1; wr0 = 1; dev0 = 8'h03; addr0 = 16'h0002; wd0 = 8'hA5;
    run_txn("write0", 1'b0, 8'h00, 1'b0);
    req1 = 1; wr1 = 0; dev1 = 8'h07; addr1 = 16'h0001; wd1 = 8'h11;
    run_txn("read1", 1'b1, 8'h5C, 1'b0);
    req0 = 1; wr0 = 1; dev0 = 8'h21; addr0 = 16'hBEEF; wd0 = 8'h3C;
    run_txn("write0b", 1'b0, 8'h00, 1'b0);

    // Reset in the first STROBE cycle: strobes drop asynchronously, no Ack
    req0 = 1; wr0 = 1; dev0 = 8'h44; addr0 = 16'h1234; wd0 = 8'h99;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("abort/strobe", 32'(ctl()), 32'b01100);
    #2 n_reset = 1'b0;
    #1 chk("abort/async", 32'(ctl()), 32'd0);
    chk("abort/bus", {bus_dev, bus_addr, bus_dout, rdata}, 32'd0);
    req0 = 0;
    m_last = 1'b1;
    m_rdata = 8'h00;
    @(negedge clk);
    n_reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("abort/noack%0d", i), 32'(ctl()), 32'd0);
    end

    // Contention after reset: both requests held, grants alternate from 0
    for (int i = 0; i < 4; i++) begin
      req0 = 1; wr0 = 1'(i); dev0 = 8'(8'h10 + i); addr0 = 16'(16'h0100 + i); wd0 = 8'($urandom);
      req1 = 1; wr1 = 1'(~i); dev1 = 8'(8'h20 + i); addr1 = 16'(16'h0200 + i); wd1 = 8'($urandom);
      run_txn($sformatf("contend%0d", i), 1'b0, 8'h00, 1'b0);
      chk($sformatf("contend%0d/owner", i), 32'(m_last), 32'(i % 2));
    end
    req0 = 0; req1 = 0;
    @(negedge clk);

    // Strobe-length sweep: write then read on STROBE_CYCLES = 1 and 15
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < 2; k++) begin
        strobe_n[k] = 0; en_n[k] = 0; ack_at[k] = -1; ack_n[k] = 0;
      end
      s_req = 1; s_wr = (pass == 0); s_dev = 8'h5A; s_addr = 16'hC001; s_wd = 8'h77;
      bus_in = 8'h3C;
      for (int j = 1; j <= 20; j++) begin
        @(negedge clk);
        s_req = 0;
        for (int k = 0; k < 2; k++) begin
          strobe_n[k] += int'(s_rd[k] | s_ws[k]);
          en_n[k]     += int'(s_en[k]);
          ack_n[k]    += int'(s_a0[k] | s_a1[k]);
          if (s_a0[k] && ack_at[k] < 0) ack_at[k] = j;
        end
      end
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("sweep%0d/p%0d/width", sw_sc[k], pass), 32'(strobe_n[k]), 32'(sw_sc[k]));
        chk($sformatf("sweep%0d/p%0d/ackat", sw_sc[k], pass), 32'(ack_at[k]), 32'(sw_sc[k] + 2));
        chk($sformatf("sweep%0d/p%0d/ackn", sw_sc[k], pass), 32'(ack_n[k]), 32'd1);
        chk($sformatf("sweep%0d/p%0d/en", sw_sc[k], pass), 32'(en_n[k]),
            32'(pass == 0 ? sw_sc[k] + 2 : 0));
        if (pass == 1) chk($sformatf("sweep%0d/rdata", sw_sc[k]), 32'(s_rdata[k]), 32'h3C);
        $display("sweep STROBE_CYCLES=%0d pass=%0d: width=%0d ack_at=%0d",
                 sw_sc[k], pass, strobe_n[k], ack_at[k]);
      end
    end

    // Randomized traffic with field disturbance after grant
    for (int n = 0; n < 40; n++) begin
      if (!req0 && ($urandom_range(3) != 0)) begin
        req0 = 1; {wr0, dev0, addr0, wd0} = 33'({$urandom, $urandom});
      end
      if (!req1 && ($urandom_range(3) != 0)) begin
        req1 = 1; {wr1, dev1, addr1, wd1} = 33'({$urandom, $urandom});
      end
      if (req0 || req1) begin
        run_txn($sformatf("rand%0d", n), 1'b0, 8'h00, 1'b1);
      end else begin
        @(negedge clk);
        chk($sformatf("rand%0d/quiet", n), 32'(ctl()), 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
